// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sort constants and the pad-value helper
package sort_pkg;

    localparam int PAD_MAX_WIDTH = 64;

    function automatic int lane_counter_width(input int log_input);
        return log_input;
    endfunction

    // Pad sorts to the tail: type maximum for ascending order, type minimum for descending.
    function automatic logic [PAD_MAX_WIDTH-1:0] pad_value(input int data_width,
                                                           input bit is_signed,
                                                           input bit ascending);
        logic [PAD_MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < PAD_MAX_WIDTH; i++) begin
            if (i < data_width) v[i] = ascending;
        end
        if (is_signed && data_width > 0 && data_width <= PAD_MAX_WIDTH) begin
            v[data_width-1] = ~ascending;
        end
        return v;
    endfunction

endpackage

// File: rtl/sort_input_collector.sv
// rtl/sort_input_collector.sv - gathers a stream into N-element blocks for the sorter
// Optional early block close with padding on in_last: SORT_COLLECT_PAD_EN.
module sort_input_collector
    import sort_pkg::*;
#(
    parameter int LOG_INPUT  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 0,
    parameter int ASCENDING  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    input  logic                                  in_last,
    output logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]  x,
    output logic                                  x_valid,
    output logic [LOG_INPUT:0]                    x_count
);

    localparam int N  = 2 ** LOG_INPUT;
    localparam int CW = lane_counter_width(LOG_INPUT);
    localparam logic [PAD_MAX_WIDTH-1:0] PAD_WIDE = pad_value(DATA_WIDTH, SIGNED != 0, ASCENDING != 0);
    localparam logic [DATA_WIDTH-1:0]    PAD      = PAD_WIDE[DATA_WIDTH-1:0];

`ifdef SORT_COLLECT_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic [CW-1:0]              lane;
    logic [DATA_WIDTH*N-1:0]    fill;
    logic [DATA_WIDTH*N-1:0]    block;
    logic                       at_end;
    logic                       close_early;
    logic                       emit;

    assign at_end      = (lane == CW'(N - 1));
    assign close_early = PAD_EN && in_last;
    assign emit        = in_valid && (at_end || close_early);

    // The block as it would look with the current element merged in.
    always_comb begin
        block = fill;
        for (int i = 0; i < N; i++) begin
            if (i == int'(lane)) begin
                block[DATA_WIDTH*i +: DATA_WIDTH] = in_data;
            end else if (close_early && i > int'(lane)) begin
                block[DATA_WIDTH*i +: DATA_WIDTH] = PAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane    <= '0;
            fill    <= '0;
            x       <= '0;
            x_count <= '0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= 1'b0;
            if (in_valid) begin
                if (emit) begin
                    x       <= block;
                    x_count <= (LOG_INPUT+1)'(lane) + (LOG_INPUT+1)'(1);
                    x_valid <= 1'b1;
                    lane    <= '0;
                    fill    <= '0;
                end else begin
                    fill <= block;
                    lane <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_input_collector.sv
// tb/tb_sort_input_collector.sv - table and scoreboard bench for sort_input_collector
module tb_sort_input_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic [31:0] x_u, x_s;
    logic        v_u, v_s;
    logic [2:0]  cnt_u, cnt_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_input_collector #(.LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(0), .ASCENDING(1)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .x(x_u), .x_valid(v_u), .x_count(cnt_u));

    sort_input_collector #(.LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(1), .ASCENDING(0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .x(x_s), .x_valid(v_s), .x_count(cnt_s));

    typedef struct {
        logic [31:0] xu;
        logic [31:0] xs;
        logic [2:0]  cnt;
        int          due;
    } exp_t;

    typedef struct {
        logic [3:0][7:0] d;
        int              n;
        int              last_idx;
        int              gap;
        logic [31:0]     exp_u;
        logic [31:0]     exp_s;
        logic [2:0]      exp_cnt;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input bit push_it, input logic [31:0] eu, input logic [31:0] es,
                         input logic [2:0] ec);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        if (push_it) sbq.push_back('{eu, es, ec, cyc + 1});
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_x_u"}, x_u, 32'h0);
        chk({tag, "_x_s"}, x_s, 32'h0);
        chk({tag, "_cnt"}, {29'h0, cnt_u}, 32'h0);
        chk({tag, "_valid"}, {31'h0, v_u | v_s}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && (v_u || v_s)) begin
            chk("valid_agree", {31'h0, v_u}, {31'h0, v_s});
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: got x_valid=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pulse_cycle", cyc, e.due);
                chk("x_unsigned", x_u, e.xu);
                chk("x_signed", x_s, e.xs);
                chk("count_u", {29'h0, cnt_u}, {29'h0, e.cnt});
                chk("count_s", {29'h0, cnt_s}, {29'h0, e.cnt});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{'{8'h02, 8'h03, 8'h01, 8'h04}, 4, -1, 0, 32'h02030104, 32'h02030104, 3'd4};
        vecs[1] = '{'{8'h02, 8'h03, 8'h01, 8'h04}, 4, -1, 1, 32'h02030104, 32'h02030104, 3'd4};
        vecs[2] = '{'{8'h02, 8'h03, 8'h01, 8'h04}, 4, -1, 2, 32'h02030104, 32'h02030104, 3'd4};
        vecs[3] = '{'{8'h02, 8'h03, 8'h01, 8'h04}, 4, -1, 3, 32'h02030104, 32'h02030104, 3'd4};
`ifdef SORT_COLLECT_PAD_EN
        vecs[4] = '{'{8'h00, 8'h00, 8'h05, 8'h07}, 2, 1, 0, 32'hFFFF0507, 32'h80800507, 3'd2};
        vecs[5] = '{'{8'h44, 8'h33, 8'h22, 8'h11}, 4, 3, 0, 32'h44332211, 32'h44332211, 3'd4};
        vecs[6] = '{'{8'h00, 8'h00, 8'h00, 8'h5A}, 1, 0, 2, 32'hFFFFFF5A, 32'h8080805A, 3'd1};
        vecs[7] = '{'{8'h00, 8'h33, 8'h22, 8'h11}, 3, 2, 1, 32'hFF332211, 32'h80332211, 3'd3};
`else
        vecs[4] = '{'{8'h0B, 8'h0A, 8'h05, 8'h07}, 4, 1, 1, 32'h0B0A0507, 32'h0B0A0507, 3'd4};
        vecs[5] = '{'{8'h44, 8'h33, 8'h22, 8'h11}, 4, 2, 0, 32'h44332211, 32'h44332211, 3'd4};
        vecs[6] = '{'{8'hA1, 8'hB2, 8'hC3, 8'h5A}, 4, 0, 2, 32'hA1B2C35A, 32'hA1B2C35A, 3'd4};
        vecs[7] = '{'{8'hFE, 8'h80, 8'h7F, 8'h00}, 4, -1, 0, 32'hFE807F00, 32'hFE807F00, 3'd4};
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("init");
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                drive(1'b1, vecs[i].d[k], (k == vecs[i].last_idx), (k == vecs[i].n - 1),
                      vecs[i].exp_u, vecs[i].exp_s, vecs[i].exp_cnt);
                if (k < vecs[i].n - 1) begin
                    for (int g = 0; g < vecs[i].gap; g++)
                        drive(1'b0, 8'($urandom), 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
                end
            end
        end
        idle();

        // Partial block discarded by reset, then a clean block.
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 8'hBB, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid");
        rst = 1'b0;
        drive(1'b1, 8'h09, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 8'h08, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 8'h07, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 8'h06, 1'b0, 1'b1, 32'h06070809, 32'h06070809, 3'd4);
        idle();

        // Back-to-back blocks with no idle cycle.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 8'(k), 1'b0, (k == 4 || k == 8),
                  (k == 4) ? 32'h04030201 : 32'h08070605,
                  (k == 4) ? 32'h04030201 : 32'h08070605, 3'd4);
        end
        idle();

        repeat (6) idle();
        chk("sb_drain", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
